writeback_stage_mw: RTL and testbench
=====================================

Name: writeback_stage_mw

Overview:
- Parametrised Memory→Writeback pipeline register fused with the ResultW select.
- Supports LANES data lanes (scalar LANES=1, vector LANES>1) with per-lane write enables.
- Adds stall/flush, a valid bit, variable-latency load handling (wait FSM with timeout) and a retired-instruction counter.
- Sits between the memory stage and the register file write port. ResultW also feeds the fetch-stage PC mux and the execute-stage forwarding muxes.

Parameters:
- N, 24, data width per lane
- LANES, 1, number of data lanes
- RA, 4, register address width
- TIMEOUT, 15, max cycles to wait for load data (≥1)
- CW, 16, retired counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  global stage enable; 0 freezes everything
- StallW  in  1  hold W register (RUN state only)
- FlushW  in  1  insert bubble / abort pending load
- ValidM  in  1  M-stage holds a real instruction
- PCSrcM  in  1  control
- RegWriteM  in  1  control
- MemtoRegM  in  1  control
- LaneEnM  in  LANES  per-lane write mask
- WA3M  in  RA  destination register
- ALUOutM  in  LANES*N  ALU result, lane i at [i*N +: N]
- ReadDataM  in  LANES*N  memory read data
- ReadValidM  in  1  ReadDataM valid this cycle
- PCSrcW  out  1  registered control
- RegWriteW  out  1  registered control, gated by ValidW
- LaneWeW  out  LANES  RegWriteW & lane mask
- WA3W  out  RA  registered destination
- ResultW  out  LANES*N  selected result
- ValidW  out  1  W holds a real instruction
- HoldM  out  1  combinational: M stage must not advance
- LoadTimeout  out  1  sticky error flag
- RetiredCount  out  CW  retired instruction count

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Port clk is the clock; port rst is the reset, asserted at rst=0.
  - In reset, every registered output is 0 and the FSM is in RUN.
  - Reset mid-wait aborts the load with no write.
- FSM states: RUN and WAIT. All transitions require en=1; en=0 holds state, outputs and counters.
- RUN, priority order:
  - FlushW: bubble. ValidW=0, RegWriteW=0, PCSrcW=0, LaneWeW=0. ResultW and WA3W unchanged.
  - Else StallW: hold all outputs.
  - Else if ValidM & MemtoRegM & !ReadValidM:
    - Latch control, WA3M and LaneEnM internally.
    - Output a bubble and go to WAIT. Wait counter = 1.
  - Else, normal advance:
    - Register all control fields.
    - ValidW=ValidM; RegWriteW=RegWriteM&ValidM; PCSrcW=PCSrcM&ValidM.
    - ResultW = MemtoRegM ? ReadDataM : ALUOutM, applied to all lanes together.
    - Latency is 1 cycle M→W.
- WAIT. StallW is ignored in this state.
  - FlushW: return to RUN and output a bubble. No timeout is flagged.
  - Else ReadValidM:
    - Write ResultW=ReadDataM with the latched control; ValidW=1.
    - Return to RUN.
  - Else if the counter has reached TIMEOUT:
    - Set LoadTimeout=1 (sticky until reset).
    - Complete with ResultW=0 and latched control, ValidW=1. Return to RUN.
  - Else increment the counter and keep outputting a bubble.
- HoldM = (state==WAIT) | (RUN & en & !FlushW & !StallW & ValidM & MemtoRegM & !ReadValidM).
- LaneEnW gating: LaneWeW[i] = RegWriteW & latched LaneEn[i]. For LANES=1 this equals RegWriteW.
- RetiredCount: +1 on each edge where ValidW is loaded with 1 by an advance or a WAIT completion. A held (stalled) W is not recounted. Wraps modulo 2^CW.
- Simultaneous events:
  - FlushW beats ReadValidM.
  - ReadValidM beats timeout on the same cycle.
  - StallW in WAIT has no effect.

Test Plan:
1. Reset, then ALU op: ValidM=1, RegWriteM=1, MemtoRegM=0, ALUOutM=24'h00ABCD, WA3M=3 → next cycle ValidW=1, RegWriteW=1, WA3W=3, ResultW=24'h00ABCD, RetiredCount=1.
2. Load with 3-cycle latency: MemtoRegM=1, ReadValidM=0 for 2 cycles then 1 with ReadDataM=24'h123456 → HoldM=1 throughout the wait; ValidW=0 for 2 cycles, then ResultW=24'h123456, ValidW=1; HoldM drops.
3. Timeout, TIMEOUT=4: load with ReadValidM never asserted → after 4 WAIT cycles LoadTimeout=1, ResultW=0, ValidW=1; LoadTimeout stays 1 after later traffic until rst=0.
4. Stall/flush priority: StallW=1 for 2 cycles → outputs unchanged, RetiredCount unchanged. FlushW=1 with StallW=1 → ValidW=0, RegWriteW=0. FlushW in WAIT with ReadValidM=1 same cycle → bubble, state RUN.
5. Vector, LANES=4: LaneEnM=4'b0101, RegWriteM=1, distinct ALUOutM per lane → LaneWeW=4'b0101, each ResultW lane matches its input lane.
6. Reset mid-WAIT: rst=0 asynchronously → all outputs 0 immediately. After release, a new ALU op retires normally and RetiredCount=1 with CW=2. Four more ops → count wraps to 1.

Source files
------------

// File: rtl/writeback_stage_mw.sv
// writeback_stage_mw
//   Memory->Writeback pipeline register fused with the ResultW select.
//   Handles LANES data lanes with per-lane write enables, stall/flush, a
//   valid bit, variable-latency loads (WAIT state with timeout) and a
//   retired-instruction counter.
//
// Ports
//   clk, rst (async, active-low), en (global stage enable)
//   StallW, FlushW                       : W-stage hold / bubble insertion
//   ValidM, PCSrcM, RegWriteM, MemtoRegM : M-stage control
//   LaneEnM, WA3M                        : lane write mask, destination register
//   ALUOutM, ReadDataM, ReadValidM       : M-stage data, lane i at [i*N +: N]
//   PCSrcW, RegWriteW, LaneWeW, WA3W     : registered W-stage control
//   ResultW, ValidW                      : selected result and its valid bit
//   HoldM                                : combinational back-pressure to M
//   LoadTimeout                          : sticky "load never returned" flag
//   RetiredCount                         : wrapping retired-instruction count
module writeback_stage_mw #(
    parameter int N       = 24,
    parameter int LANES   = 1,
    parameter int RA      = 4,
    parameter int TIMEOUT = 15,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               StallW,
    input  logic               FlushW,
    input  logic               ValidM,
    input  logic               PCSrcM,
    input  logic               RegWriteM,
    input  logic               MemtoRegM,
    input  logic [LANES-1:0]   LaneEnM,
    input  logic [RA-1:0]      WA3M,
    input  logic [LANES*N-1:0] ALUOutM,
    input  logic [LANES*N-1:0] ReadDataM,
    input  logic               ReadValidM,
    output logic               PCSrcW,
    output logic               RegWriteW,
    output logic [LANES-1:0]   LaneWeW,
    output logic [RA-1:0]      WA3W,
    output logic [LANES*N-1:0] ResultW,
    output logic               ValidW,
    output logic               HoldM,
    output logic               LoadTimeout,
    output logic [CW-1:0]      RetiredCount
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [TW-1:0]     wait_cnt;

    // Control of the load parked in WAIT; replayed when its data arrives.
    logic              pcsrc_p0;
    logic              regwrite_p0;
    logic [LANES-1:0]  lane_en_p0;
    logic [RA-1:0]     wa3_p0;

    // Lane mask of the instruction currently in W.
    logic [LANES-1:0]  lane_en_p1;

    logic              load_miss;

    assign load_miss = ValidM & MemtoRegM & ~ReadValidM;

    assign HoldM = (state == S_WAIT) |
                   ((state == S_RUN) & en & ~FlushW & ~StallW & load_miss);

    // RegWriteW already carries the valid gating, so bubbles never write.
    assign LaneWeW = {LANES{RegWriteW}} & lane_en_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            pcsrc_p0     <= 1'b0;
            regwrite_p0  <= 1'b0;
            lane_en_p0   <= '0;
            wa3_p0       <= '0;
            lane_en_p1   <= '0;
            PCSrcW       <= 1'b0;
            RegWriteW    <= 1'b0;
            WA3W         <= '0;
            ResultW      <= '0;
            ValidW       <= 1'b0;
            LoadTimeout  <= 1'b0;
            RetiredCount <= '0;
        end else if (en) begin
            case (state)
                // ---- RUN: flush > stall > load miss > normal advance ----
                S_RUN: begin
                    if (FlushW) begin
                        ValidW    <= 1'b0;
                        RegWriteW <= 1'b0;
                        PCSrcW    <= 1'b0;
                    end else if (!StallW) begin
                        if (load_miss) begin
                            pcsrc_p0    <= PCSrcM;
                            regwrite_p0 <= RegWriteM;
                            lane_en_p0  <= LaneEnM;
                            wa3_p0      <= WA3M;
                            ValidW      <= 1'b0;
                            RegWriteW   <= 1'b0;
                            PCSrcW      <= 1'b0;
                            wait_cnt    <= TW'(1);
                            state       <= S_WAIT;
                        end else begin
                            ValidW     <= ValidM;
                            RegWriteW  <= RegWriteM & ValidM;
                            PCSrcW     <= PCSrcM & ValidM;
                            WA3W       <= WA3M;
                            lane_en_p1 <= LaneEnM;
                            ResultW    <= MemtoRegM ? ReadDataM : ALUOutM;
                            if (ValidM) begin
                                RetiredCount <= RetiredCount + CW'(1);
                            end
                        end
                    end
                end
                // ---- WAIT: flush > data return > timeout > keep waiting ----
                S_WAIT: begin
                    if (FlushW) begin
                        ValidW    <= 1'b0;
                        RegWriteW <= 1'b0;
                        PCSrcW    <= 1'b0;
                        state     <= S_RUN;
                    end else if (ReadValidM || (wait_cnt == TW'(TIMEOUT))) begin
                        // A timed-out load still retires, with zero data, so
                        // the destination register is not left stale.
                        if (!ReadValidM) begin
                            LoadTimeout <= 1'b1;
                        end
                        ResultW      <= ReadValidM ? ReadDataM : '0;
                        ValidW       <= 1'b1;
                        RegWriteW    <= regwrite_p0;
                        PCSrcW       <= pcsrc_p0;
                        WA3W         <= wa3_p0;
                        lane_en_p1   <= lane_en_p0;
                        RetiredCount <= RetiredCount + CW'(1);
                        state        <= S_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage_mw.sv
module tb_writeback_stage_mw;

    localparam int N       = 24;
    localparam int LANES   = 4;
    localparam int RA      = 4;
    localparam int TIMEOUT = 4;
    localparam int CW      = 2;
    localparam int W       = LANES * N;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en, StallW, FlushW, ValidM, PCSrcM, RegWriteM, MemtoRegM, ReadValidM;
    logic [LANES-1:0] LaneEnM;
    logic [RA-1:0]    WA3M;
    logic [W-1:0]     ALUOutM, ReadDataM;
    logic             PCSrcW, RegWriteW, ValidW, HoldM, LoadTimeout;
    logic [LANES-1:0] LaneWeW;
    logic [RA-1:0]    WA3W;
    logic [W-1:0]     ResultW;
    logic [CW-1:0]    RetiredCount;

    typedef struct packed {
        logic [W-1:0]     res;
        logic [RA-1:0]    wa3;
        logic [LANES-1:0] we;
        logic             pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ret   = 0;

    always #5 clk = ~clk;

    writeback_stage_mw #(.N(N), .LANES(LANES), .RA(RA), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .LaneEnM(LaneEnM), .WA3M(WA3M), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .ReadValidM(ReadValidM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .LaneWeW(LaneWeW),
        .WA3W(WA3W), .ResultW(ResultW), .ValidW(ValidW), .HoldM(HoldM),
        .LoadTimeout(LoadTimeout), .RetiredCount(RetiredCount)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        en = 1'b1; StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0; PCSrcM = 1'b0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; ReadValidM = 1'b0; LaneEnM = '0;
        WA3M = '0; ALUOutM = '0; ReadDataM = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        idle();
        exp_q.delete();
        ret = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive a completing instruction (ALU op, or load with data ready) and
    // record what W must show one cycle later.
    task automatic drive_op(input logic [RA-1:0] wa, input logic [LANES-1:0] le,
                            input logic [W-1:0] v, input logic pc, input logic mem);
        ValidM = 1'b1; RegWriteM = 1'b1; PCSrcM = pc; MemtoRegM = mem; ReadValidM = mem;
        WA3M = wa; LaneEnM = le;
        ALUOutM   = mem ? ~v : v;
        ReadDataM = mem ? v : ~v;
        exp_q.push_back('{res: v, wa3: wa, we: le, pc: pc});
        ret++;
    endtask

    task automatic drive_load_miss(input logic [RA-1:0] wa, input logic [LANES-1:0] le);
        ValidM = 1'b1; RegWriteM = 1'b1; PCSrcM = 1'b0; MemtoRegM = 1'b1; ReadValidM = 1'b0;
        WA3M = wa; LaneEnM = le; ALUOutM = {LANES{24'hDEAD00}}; ReadDataM = {LANES{24'hBAD0BA}};
    endtask

    task automatic sb_pop(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = ok ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ValidW, RegWriteW, PCSrcW, LaneWeW, WA3W, ResultW, LoadTimeout, RetiredCount} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {ValidW, RegWriteW, PCSrcW, LaneWeW, WA3W, ResultW, LoadTimeout, RetiredCount});
        end
        total++;
        if (HoldM !== 1'b0) begin bad++; $display("FAIL reset_holdm: got %b want 0", HoldM); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        exp_t e; bit ok;
        @(negedge clk);
        drive_op(4'd3, 4'hF, {LANES{24'h00ABCD}}, 1'b0, 1'b0);
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || ValidW !== 1'b1 || RegWriteW !== 1'b1 ||
            {ResultW, WA3W, LaneWeW, PCSrcW} !== {e.res, e.wa3, e.we, e.pc}) begin
            bad++;
            $display("FAIL alu_out: got v=%b rw=%b %h want v=1 rw=1 %h", ValidW, RegWriteW,
                     {ResultW, WA3W, LaneWeW, PCSrcW}, e);
        end
        total++;
        if (RetiredCount !== CW'(ret)) begin
            bad++; $display("FAIL alu_count: got %0d want %0d", RetiredCount, CW'(ret));
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_load();
        exp_t e; bit ok;
        @(negedge clk);
        drive_load_miss(4'd5, 4'b0011);
        #1;
        total++;
        if (HoldM !== 1'b1) begin bad++; $display("FAIL load_hold_run: got %b want 1", HoldM); end
        tick();
        total++;
        if (ValidW !== 1'b0 || HoldM !== 1'b1) begin
            bad++; $display("FAIL load_wait1: got v=%b h=%b want v=0 h=1", ValidW, HoldM);
        end
        tick();
        total++;
        if (ValidW !== 1'b0 || HoldM !== 1'b1) begin
            bad++; $display("FAIL load_wait2: got v=%b h=%b want v=0 h=1", ValidW, HoldM);
        end
        // Data returns; StallW must be ignored while waiting.
        @(negedge clk);
        StallW = 1'b1; ReadValidM = 1'b1; ReadDataM = {LANES{24'h123456}};
        exp_q.push_back('{res: {LANES{24'h123456}}, wa3: 4'd5, we: 4'b0011, pc: 1'b0});
        ret++;
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || ValidW !== 1'b1 || {ResultW, WA3W, LaneWeW, PCSrcW} !== {e.res, e.wa3, e.we, e.pc}) begin
            bad++;
            $display("FAIL load_done: got v=%b %h want v=1 %h", ValidW, {ResultW, WA3W, LaneWeW, PCSrcW}, e);
        end
        total++;
        if (HoldM !== 1'b0 || RetiredCount !== CW'(ret)) begin
            bad++; $display("FAIL load_release: got h=%b cnt=%0d want h=0 cnt=%0d", HoldM, RetiredCount, CW'(ret));
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_timeout();
        exp_t e; bit ok;
        reset_dut();
        drive_load_miss(4'd7, 4'hF);
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            total++;
            if (ValidW !== 1'b0 || LoadTimeout !== 1'b0 || HoldM !== 1'b1) begin
                bad++;
                $display("FAIL timeout_wait%0d: got v=%b to=%b h=%b want v=0 to=0 h=1", i, ValidW, LoadTimeout, HoldM);
            end
            tick();
        end
        exp_q.push_back('{res: '0, wa3: 4'd7, we: 4'hF, pc: 1'b0});
        ret++;
        sb_pop(e, ok);
        total++;
        if (!ok || ValidW !== 1'b1 || LoadTimeout !== 1'b1 ||
            {ResultW, WA3W, LaneWeW} !== {e.res, e.wa3, e.we}) begin
            bad++;
            $display("FAIL timeout_done: got v=%b to=%b %h want v=1 to=1 %h", ValidW, LoadTimeout,
                     {ResultW, WA3W, LaneWeW}, {e.res, e.wa3, e.we});
        end
        @(negedge clk);
        idle();
        drive_op(4'd9, 4'hF, {LANES{24'h0F0F0F}}, 1'b1, 1'b0);
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || LoadTimeout !== 1'b1 || {ResultW, WA3W, LaneWeW, PCSrcW} !== {e.res, e.wa3, e.we, e.pc}) begin
            bad++;
            $display("FAIL timeout_sticky: got to=%b %h want to=1 %h", LoadTimeout, {ResultW, WA3W, LaneWeW, PCSrcW}, e);
        end
        reset_dut();
        total++;
        if (LoadTimeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", LoadTimeout); end
    endtask

    task automatic test_stall_flush();
        exp_t e; bit ok;
        logic [W-1:0] held;
        reset_dut();
        held = {24'hA4A4A4, 24'hA3A3A3, 24'hA2A2A2, 24'hA1A1A1};
        drive_op(4'd2, 4'hF, held, 1'b1, 1'b0);
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || {ResultW, WA3W, LaneWeW, PCSrcW} !== {e.res, e.wa3, e.we, e.pc}) begin
            bad++; $display("FAIL stall_pre: got %h want %h", {ResultW, WA3W, LaneWeW, PCSrcW}, e);
        end
        @(negedge clk);
        StallW = 1'b1; WA3M = 4'd11; ALUOutM = {LANES{24'h555555}}; PCSrcM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (ValidW !== 1'b1 || ResultW !== held || WA3W !== 4'd2 || PCSrcW !== 1'b1 ||
                RetiredCount !== CW'(ret)) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b r=%h wa=%0d cnt=%0d want v=1 r=%h wa=2 cnt=%0d",
                         i, ValidW, ResultW, WA3W, RetiredCount, held, CW'(ret));
            end
        end
        @(negedge clk);
        FlushW = 1'b1;
        tick();
        total++;
        if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || PCSrcW !== 1'b0 || LaneWeW !== '0 ||
            ResultW !== held || WA3W !== 4'd2) begin
            bad++;
            $display("FAIL flush_over_stall: got v=%b rw=%b pc=%b we=%b r=%h wa=%0d want bubble r=%h wa=2",
                     ValidW, RegWriteW, PCSrcW, LaneWeW, ResultW, WA3W, held);
        end
        @(negedge clk);
        idle();
        drive_load_miss(4'd6, 4'hF);
        tick();
        @(negedge clk);
        FlushW = 1'b1; ReadValidM = 1'b1; ReadDataM = {LANES{24'h777777}};
        tick();
        idle();
        #1;
        total++;
        if (ValidW !== 1'b0 || HoldM !== 1'b0 || LoadTimeout !== 1'b0 || RetiredCount !== CW'(ret)) begin
            bad++;
            $display("FAIL flush_in_wait: got v=%b h=%b to=%b cnt=%0d want v=0 h=0 to=0 cnt=%0d",
                     ValidW, HoldM, LoadTimeout, RetiredCount, CW'(ret));
        end
    endtask

    task automatic test_vector();
        exp_t e; bit ok;
        reset_dut();
        drive_op(4'd4, 4'b0101, {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 1'b1, 1'b0);
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || LaneWeW !== 4'b0101 || PCSrcW !== 1'b1) begin
            bad++; $display("FAIL vec_lanewe: got we=%b pc=%b want we=0101 pc=1", LaneWeW, PCSrcW);
        end
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (ResultW[i*N +: N] !== e.res[i*N +: N]) begin
                bad++; $display("FAIL vec_lane%0d: got %h want %h", i, ResultW[i*N +: N], e.res[i*N +: N]);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_enable();
        exp_t e; bit ok;
        reset_dut();
        drive_op(4'd8, 4'hF, {LANES{24'h0A0B0C}}, 1'b0, 1'b1);
        tick();
        sb_pop(e, ok);
        total++;
        if (!ok || ValidW !== 1'b1 || {ResultW, WA3W, LaneWeW} !== {e.res, e.wa3, e.we}) begin
            bad++; $display("FAIL en_pre: got %h want %h", {ResultW, WA3W, LaneWeW}, {e.res, e.wa3, e.we});
        end
        @(negedge clk);
        en = 1'b0;
        drive_load_miss(4'd1, 4'h1);
        #1;
        total++;
        if (HoldM !== 1'b0) begin bad++; $display("FAIL en_holdm: got %b want 0", HoldM); end
        tick();
        total++;
        if (ValidW !== 1'b1 || ResultW !== e.res || WA3W !== 4'd8 || RetiredCount !== CW'(ret)) begin
            bad++;
            $display("FAIL en_freeze: got v=%b r=%h wa=%0d cnt=%0d want v=1 r=%h wa=8 cnt=%0d",
                     ValidW, ResultW, WA3W, RetiredCount, e.res, CW'(ret));
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ok;
        reset_dut();
        drive_load_miss(4'd12, 4'hF);
        tick();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ValidW, RegWriteW, PCSrcW, LaneWeW, WA3W, ResultW, LoadTimeout, RetiredCount} !== '0) begin
            bad++;
            $display("FAIL midwait_reset: got %h want 0",
                     {ValidW, RegWriteW, PCSrcW, LaneWeW, WA3W, ResultW, LoadTimeout, RetiredCount});
        end
        exp_q.delete();
        ret = 0;
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_op(RA'(k + 1), LANES'(k + 1), {LANES{N'($urandom)}}, k[0], k[1]);
            tick();
            sb_pop(e, ok);
            total++;
            if (!ok || ValidW !== 1'b1 || {ResultW, WA3W, LaneWeW, PCSrcW} !== {e.res, e.wa3, e.we, e.pc}) begin
                bad++;
                $display("FAIL b2b_out%0d: got v=%b %h want v=1 %h", k, ValidW, {ResultW, WA3W, LaneWeW, PCSrcW}, e);
            end
            total++;
            if (RetiredCount !== CW'(k + 1)) begin
                bad++; $display("FAIL b2b_count%0d: got %0d want %0d", k, RetiredCount, CW'(k + 1));
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_timeout();
        test_stall_flush();
        test_vector();
        test_enable();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
